// File: rtl/cla_term_pipe_stage_if.sv
// Bundle of all handshake and payload signals around the CLA term pipeline stage.
// The stage attaches through the slave modport; the upstream/downstream driver uses master.
interface cla_term_pipe_stage_if #(
    parameter int WIDTH  = 4,
    parameter int NTERMS = 25
);
    // Handshake: a word moves on any rising clk edge where valid & ready are both 1.
    // The producer holds valid and payload steady until that edge, and ready never
    // depends combinationally on valid (it comes from registered state only).
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic [NTERMS-1:0] n_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  a_out;
    logic [WIDTH-1:0]  b_out;
    logic [NTERMS-1:0] n_out;
    logic [1:0]        occ;

    modport master (
        output in_valid, a_in, b_in, n_in, out_ready,
        input  in_ready, out_valid, a_out, b_out, n_out, occ
    );

    modport slave (
        input  in_valid, a_in, b_in, n_in, out_ready,
        output in_ready, out_valid, a_out, b_out, n_out, occ
    );
endinterface

// File: rtl/cla_term_pipe_stage.sv
// Registered glitch barrier between the nonlinear and linear halves of the decomposed
// CLA adder: a 2-entry skid stage (main register M drives outputs, S absorbs one stall).
module cla_term_pipe_stage #(
    parameter int                WIDTH     = 4,
    parameter int                NTERMS    = 25,
    parameter logic [NTERMS-1:0] TERM_MASK = 25'h04C9C99
) (
    input logic                  clk,
    input logic                  rst,
    cla_term_pipe_stage_if.slave bus
);
    // Encoding equals the entry count, so occ doubles as the FSM debug view.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  m_a, m_b, s_a, s_b;
    logic [NTERMS-1:0] m_n, s_n;
    logic [NTERMS-1:0] pay_n;
    logic              in_xfer, out_xfer;
    logic              load_m_in, load_m_s, load_s;

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.occ       = state_q;
    assign bus.a_out     = m_a;
    assign bus.b_out     = m_b;
    assign bus.n_out     = m_n;

    assign in_xfer  = bus.in_valid  & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;
    // Unused terms are dropped here so they never reach a flop.
    assign pay_n    = bus.n_in & TERM_MASK;

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    load_m_in = 1'b1;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b10: begin
                        state_d = FULL;
                        load_s  = 1'b1;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: load_m_in = 1'b1;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (out_xfer) begin
                    state_d  = ONE;
                    load_m_s = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            m_a     <= '0;
            m_b     <= '0;
            m_n     <= '0;
            s_a     <= '0;
            s_b     <= '0;
            s_n     <= '0;
        end else begin
            state_q <= state_d;
            if (load_m_in) begin
                m_a <= bus.a_in;
                m_b <= bus.b_in;
                m_n <= pay_n;
            end else if (load_m_s) begin
                m_a <= s_a;
                m_b <= s_b;
                m_n <= s_n;
            end
            if (load_s) begin
                s_a <= bus.a_in;
                s_b <= bus.b_in;
                s_n <= pay_n;
            end
        end
    end
endmodule

// File: tb/tb_cla_term_pipe_stage.sv
// Randomized self-checking bench for cla_term_pipe_stage: directed handshake cases
// plus 1000 random payloads against a FIFO reference model of capacity two.
module tb_cla_term_pipe_stage;
    localparam int                WIDTH  = 4;
    localparam int                NTERMS = 25;
    localparam int                PW     = 2 * WIDTH + NTERMS;
    localparam logic [NTERMS-1:0] MASK   = 25'h04C9C99;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_term_pipe_stage_if #(.WIDTH(WIDTH), .NTERMS(NTERMS)) bus ();

    cla_term_pipe_stage #(.WIDTH(WIDTH), .NTERMS(NTERMS), .TERM_MASK(MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_out_xfer = 0;

    logic [PW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // ---------------- reference model: a two-deep FIFO of masked payloads ----------
    logic          pend_in, pend_out, stall_prev;
    logic [PW-1:0] pend_pay, held_pay;

    always @(negedge clk) begin
        if (rst) begin
            pend_in    = 1'b0;
            pend_out   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            int cnt;
            logic [PW-1:0] obs_pay;
            cnt     = exp_q.size();
            obs_pay = {bus.a_out, bus.b_out, bus.n_out};
            check("occ", 64'(bus.occ), 64'(cnt));
            check("in_ready", 64'(bus.in_ready), 64'(cnt < 2));
            check("out_valid", 64'(bus.out_valid), 64'(cnt > 0));
            if (cnt > 0) check("payload", 64'(obs_pay), 64'(exp_q[0]));
            if (stall_prev) check("stall_hold", 64'(obs_pay), 64'(held_pay));
            pend_in    = bus.in_valid && (cnt < 2);
            pend_pay   = {bus.a_in, bus.b_in, bus.n_in & MASK};
            pend_out   = bus.out_ready && (cnt > 0);
            stall_prev = (cnt > 0) && !bus.out_ready;
            held_pay   = obs_pay;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (pend_out) begin
                void'(exp_q.pop_front());
                n_out_xfer++;
            end
            if (pend_in) exp_q.push_back(pend_pay);
            pend_in  = 1'b0;
            pend_out = 1'b0;
        end
    end

    // ---------------- driver tasks ------------------------------------------------
    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Offers one payload and holds it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [NTERMS-1:0] n);
        logic acc;
        int   waited;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.n_in     = n;
        acc          = 1'b0;
        waited       = 0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 200) begin
                check("send_timeout", 64'(waited), 64'(0));
                break;
            end
        end
    endtask

    task automatic drain();
        int i;
        bus.out_ready = 1'b1;
        for (i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- stimulus ------------------------------------------------------
    logic [WIDTH-1:0] sum;
    int               base;
    logic             send_done;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.n_in      = '0;
        bus.out_ready = 1'b0;

        // reset state
        #3;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_occ", 64'(bus.occ), 64'(0));
        check("rst_data", 64'({bus.a_out, bus.b_out, bus.n_out}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single payload, latency 1, sum as the linear part would form it
        bus.out_ready = 1'b1;
        send(4'h3, 4'h5, 25'h0080011);
        idle();
        @(negedge clk);
        check("first_valid", 64'(bus.out_valid), 64'(1));
        check("first_n", 64'(bus.n_out), 64'(25'h0080011));
        sum = bus.a_out + bus.b_out;
        check("first_sum", 64'(sum), 64'(4'h8));
        drain();

        // mask applied on capture
        send(4'hF, 4'hF, 25'h1FFFFFF);
        idle();
        @(negedge clk);
        check("mask_n", 64'(bus.n_out), 64'(25'h04C9C99));
        drain();

        // backpressure: fill both entries, third payload waits upstream
        bus.out_ready = 1'b0;
        send(4'h1, 4'h0, 25'h0000001);
        send(4'h2, 4'h0, 25'h0000008);
        @(negedge clk);
        check("bp_occ", 64'(bus.occ), 64'(2));
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        #1;
        fork
            send(4'h3, 4'h0, 25'h0000010);
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // streaming: one word per cycle, occ stays 1
        base = n_out_xfer;
        for (int k = 0; k < 16; k++) send(4'(k), 4'(15 - k), 25'($urandom));
        idle();
        @(posedge clk);
        #1;
        check("stream_count", 64'(n_out_xfer - base), 64'(16));
        drain();

        // random traffic with random stalls
        send_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    idle();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(4'($urandom), 4'($urandom), 25'($urandom));
                end
                idle();
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        // asynchronous reset while FULL
        bus.out_ready = 1'b0;
        send(4'hA, 4'h1, 25'h0000099);
        send(4'hB, 4'h2, 25'h0000C00);
        idle();
        @(negedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_in_ready", 64'(bus.in_ready), 64'(1));
        check("arst_occ", 64'(bus.occ), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send(4'h9, 4'h6, 25'h0400000);
        idle();
        @(negedge clk);
        check("post_rst_a", 64'(bus.a_out), 64'(4'h9));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
